// File: rtl/io_mmio_bridge_pkg.sv
// Shared constants for the board I/O MMIO bridge: register offsets,
// the IRQ enable bit position and the default register window base.
package io_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  localparam logic [3:0] DISPLAY_OFF = 4'h0;
  localparam logic [3:0] SWITCH_OFF  = 4'h4;
  localparam logic [3:0] EVENTS_OFF  = 4'h8;
  localparam logic [3:0] BTN_OFF     = 4'hC;

  localparam int IRQ_EN_BIT = 31;

endpackage

// File: rtl/io_mmio_bridge_debounce.sv
// Per-bit input conditioner: 2-flop synchroniser followed by a debouncer that
// only adopts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module io_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_sync != r_stable) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  // High in the cycle before stable goes 0->1, so the event lands on the same edge.
  assign rise   = w_done & r_sync;

endmodule

// File: rtl/io_mmio_bridge.sv
// MMIO bridge for display value, debounced switches/buttons and button events.
// Optional IO_IRQ_EN adds the irq output and the IRQ_EN bit at offset 0xC[31].
module io_mmio_bridge
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          NUM_SW          = 8,
  parameter int          NUM_BTN         = 4,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [31:0]        bus_rdata,
  output logic               bus_rvalid,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [31:0]        disp_num
`ifdef IO_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic [NUM_SW-1:0]  w_sw_stable;
  logic [NUM_SW-1:0]  w_sw_rise_unused;
  logic [NUM_BTN-1:0] w_btn_stable;
  logic [NUM_BTN-1:0] w_btn_rise;
  logic [1:0]         w_addr_unused;

  logic [31:0]        r_disp;
  logic [31:0]        r_rdata;
  logic               r_rvalid;
  logic [NUM_BTN-1:0] r_events;

  logic               w_hit;
  logic [3:0]         w_off;
  logic               w_wr;
  logic               w_rd;
  logic [NUM_BTN-1:0] w_clr;
  logic [31:0]        w_rmux;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_in[i]),
      .stable (w_sw_stable[i]),
      .rise   (w_sw_rise_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_in[i]),
      .stable (w_btn_stable[i]),
      .rise   (w_btn_rise[i])
    );
  end

  assign w_addr_unused = bus_addr[1:0];
  assign w_hit = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off = {bus_addr[3:2], 2'b00};
  assign w_wr  = bus_we & w_hit;
  // A simultaneous write wins over the read; the read is dropped entirely.
  assign w_rd  = bus_re & ~bus_we;
  assign w_clr = (w_wr && (w_off == EVENTS_OFF)) ? bus_wdata[NUM_BTN-1:0] : '0;

`ifdef IO_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_off == BTN_OFF)) r_irq_en <= bus_wdata[IRQ_EN_BIT];
      r_irq <= r_irq_en & (|r_events);
    end
  end

  assign irq = r_irq;
`endif

  always_comb begin
    w_rmux = '0;
    if (w_hit) begin
      case (w_off)
        DISPLAY_OFF: w_rmux = r_disp;
        SWITCH_OFF:  w_rmux = 32'(w_sw_stable);
        EVENTS_OFF:  w_rmux = 32'(r_events);
        BTN_OFF: begin
          w_rmux = 32'(w_btn_stable);
`ifdef IO_IRQ_EN
          w_rmux[IRQ_EN_BIT] = r_irq_en;
`endif
        end
        default: w_rmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp   <= '0;
      r_events <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr && (w_off == DISPLAY_OFF)) r_disp <= bus_wdata;
      // Set has priority over a same-cycle write-1-to-clear.
      r_events <= (r_events & ~w_clr) | w_btn_rise;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rmux;
    end
  end

  assign disp_num   = r_disp;
  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Directed-vector bench for io_mmio_bridge with DEBOUNCE_CYCLES=4.
module tb_io_mmio_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int NUM_SW  = 8;
  localparam int NUM_BTN = 4;
  localparam int DB      = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        bus_addr = '0;
  logic [31:0]        bus_wdata = '0;
  logic               bus_we = 1'b0;
  logic               bus_re = 1'b0;
  logic [31:0]        bus_rdata;
  logic               bus_rvalid;
  logic [NUM_SW-1:0]  sw_in = '0;
  logic [NUM_BTN-1:0] btn_in = '0;
  logic [31:0]        disp_num;
`ifdef IO_IRQ_EN
  logic               irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  io_mmio_bridge #(
    .BASE_ADDR       (BASE),
    .NUM_SW          (NUM_SW),
    .NUM_BTN         (NUM_BTN),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .sw_in      (sw_in),
    .btn_in     (btn_in),
    .disp_num   (disp_num)
`ifdef IO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a;
    bus_re   = 1'b1;
    tick();
    bus_re   = 1'b0;
    check_vec({tag, "_rvalid"}, {31'd0, bus_rvalid}, 32'd1);
    check_vec({tag, "_rdata"}, bus_rdata, exp);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_vec("rst_disp", disp_num, 32'h0);
    check_vec("rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
    check_vec("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Display write and read-back
    bus_write(BASE + 32'h0, 32'h0000_1234);
    check_vec("disp_wr", disp_num, 32'h0000_1234);
    rd_check("disp_rd", BASE + 32'h0, 32'h0000_1234);
    tick();
    check_vec("rvalid_pulse_end", {31'd0, bus_rvalid}, 32'd0);

    // Switch debounce latency: read at 6th edge still sees old level
    sw_in = 8'hA5;
    tick(5);
    rd_check("sw_early", BASE + 32'h4, 32'h0);
    rd_check("sw_settled", BASE + 32'h4, 32'h0000_00A5);

    // 2-cycle glitch is filtered
    sw_in = 8'h00;
    tick(2);
    sw_in = 8'hA5;
    tick(2);
    rd_check("sw_glitch_mid", BASE + 32'h4, 32'h0000_00A5);
    tick(8);
    rd_check("sw_glitch_end", BASE + 32'h4, 32'h0000_00A5);

    // Clean press/release of btn[2]
    btn_in = 4'h4;
    tick(8);
    rd_check("btn_level_press", BASE + 32'hC, 32'h4);
    btn_in = 4'h0;
    tick(8);
    rd_check("btn_level_rel", BASE + 32'hC, 32'h0);
    rd_check("ev_btn2", BASE + 32'h8, 32'h4);
    bus_write(BASE + 32'h8, 32'h0);
    rd_check("ev_w0_keep", BASE + 32'h8, 32'h4);
    bus_write(BASE + 32'h8, 32'h4);
    rd_check("ev_w1c", BASE + 32'h8, 32'h0);

    // Set wins over same-cycle clear on btn[0]
    btn_in = 4'h1;
    tick(5);
    bus_write(BASE + 32'h8, 32'h1);
    rd_check("ev_set_wins", BASE + 32'h8, 32'h1);
    btn_in = 4'h0;
    tick(8);
    bus_write(BASE + 32'h8, 32'h1);
    rd_check("ev_clear0", BASE + 32'h8, 32'h0);

    // Miss read and write/read collision
    rd_check("disp_rd2", BASE + 32'h0, 32'h0000_1234);
    rd_check("miss_rd", BASE + 32'h10, 32'h0);
    bus_addr  = BASE;
    bus_wdata = 32'h0000_00FF;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    tick();
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    check_vec("coll_disp", disp_num, 32'h0000_00FF);
    check_vec("coll_norvalid", {31'd0, bus_rvalid}, 32'd0);

    // Back-to-back reads
    bus_addr = BASE + 32'h0;
    bus_re   = 1'b1;
    tick();
    check_vec("b2b_1_rvalid", {31'd0, bus_rvalid}, 32'd1);
    check_vec("b2b_1_rdata", bus_rdata, 32'h0000_00FF);
    bus_addr = BASE + 32'h4;
    tick();
    bus_re   = 1'b0;
    check_vec("b2b_2_rvalid", {31'd0, bus_rvalid}, 32'd1);
    check_vec("b2b_2_rdata", bus_rdata, 32'h0000_00A5);

    // Ignored writes: RO register, miss, and 0xC
    bus_write(BASE + 32'h4, 32'h0);
    rd_check("ro_sw", BASE + 32'h4, 32'h0000_00A5);
    bus_write(BASE + 32'h10, 32'h0000_0055);
    check_vec("miss_wr", disp_num, 32'h0000_00FF);
    bus_write(BASE + 32'hC, 32'h8000_0000);
`ifdef IO_IRQ_EN
    rd_check("irq_en_rd", BASE + 32'hC, 32'h8000_0000);
    btn_in = 4'h2;
    tick(8);
    check_vec("irq_set", {31'd0, irq}, 32'd1);
    bus_write(BASE + 32'h8, 32'h2);
    check_vec("irq_lag", {31'd0, irq}, 32'd1);
    tick();
    check_vec("irq_clr", {31'd0, irq}, 32'd0);
    btn_in = 4'h0;
    tick(8);
`else
    rd_check("btn_wr_ign", BASE + 32'hC, 32'h0);
`endif

    // Reset mid-debounce with pending read data
    bus_write(BASE + 32'h0, 32'hDEAD_BEEF);
    sw_in = 8'h3C;
    tick(3);
    rd_check("pre_rst_rd", BASE + 32'h0, 32'hDEAD_BEEF);
    rst = 1'b0;
    #1;
    check_vec("rst_mid_disp", disp_num, 32'h0);
    check_vec("rst_mid_rvalid", {31'd0, bus_rvalid}, 32'd0);
    check_vec("rst_mid_rdata", bus_rdata, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(5);
    rd_check("sw_post_rst_early", BASE + 32'h4, 32'h0);
    rd_check("sw_post_rst", BASE + 32'h4, 32'h0000_003C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
